// File: rtl/game_flow_ctrl_if.sv
// Handshake bundle between the game sequencer and the sprite/judge/pixel-mux blocks.
`timescale 1ns/1ps
interface game_flow_ctrl_if;
  logic        tick;
  logic        enter;
  logic        pause_key;
  logic        enemy_kill;
  logic        boss_kill;
  logic        player_hit;
  logic [2:0]  state;
  logic        play_en;
  logic        freeze;
  logic        round_rst;
  logic        boss_spawn;
  logic [1:0]  lives;
  logic        invuln;
  logic [15:0] score_bcd;
  logic [15:0] hiscore_bcd;

  modport slave (
    input  tick, enter, pause_key, enemy_kill, boss_kill, player_hit,
    output state, play_en, freeze, round_rst, boss_spawn, lives, invuln,
           score_bcd, hiscore_bcd
  );

  modport master (
    output tick, enter, pause_key, enemy_kill, boss_kill, player_hit,
    input  state, play_en, freeze, round_rst, boss_spawn, lives, invuln,
           score_bcd, hiscore_bcd
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-phase sequencer: phase FSM, lives, saturating BCD score, invulnerability and end-screen hold.
// Optional best-score register enabled by defining GAME_HISCORE_EN.
`timescale 1ns/1ps
module game_flow_ctrl #(
  parameter logic [1:0]  LIVES_INIT   = 2'd3,
  parameter logic [15:0] BOSS_SCORE   = 16'h0020,
  parameter logic [15:0] BOSS_POINTS  = 16'h0050,
  parameter int          INVULN_TICKS = 100,
  parameter int          OVER_HOLD    = 200
) (
  input  logic             clk,
  input  logic             rst,
  game_flow_ctrl_if.slave  bus
);

  localparam int IW = $clog2(INVULN_TICKS + 1);
  localparam int HW = $clog2(OVER_HOLD + 1);
  localparam logic [IW-1:0] INV_LOAD  = IW'(INVULN_TICKS);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(OVER_HOLD);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_BOSS  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;
  localparam logic [2:0] S_WIN   = 3'd5;

  // Digit-wise BCD add; a carry out of the thousands digit pins the result at 9999.
  function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] sum;
    logic [4:0]  d;
    logic        c;
    sum = '0;
    c   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
      if (d > 5'd9) begin
        d = d - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      sum[4*i +: 4] = d[3:0];
    end
    return c ? 16'h9999 : sum;
  endfunction

  logic [2:0]    r_state, w_state_nxt;
  logic [2:0]    r_ret, w_ret_nxt;
  logic          r_enter_d, r_pause_d;
  logic [1:0]    r_lives, w_lives_nxt;
  logic [15:0]   r_score, w_score_nxt, w_score_kill;
  logic [IW-1:0] r_inv_cnt, w_inv_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic          r_round_rst, r_boss_spawn;
  logic          w_enter_edge, w_pause_edge;
  logic          w_active, w_end, w_hit, w_fatal, w_start, w_enter_end;

  assign w_enter_edge = bus.enter & ~r_enter_d;
  assign w_pause_edge = bus.pause_key & ~r_pause_d;
  assign w_active     = (r_state == S_PLAY) | (r_state == S_BOSS);
  assign w_end        = (r_state == S_OVER) | (r_state == S_WIN);
  assign w_hit        = w_active & bus.player_hit & (r_inv_cnt == '0);
  assign w_fatal      = w_hit & (r_lives <= 2'd1);
  assign w_start      = w_enter_edge & ((r_state == S_IDLE) | (w_end & (r_hold == '0)));
  assign w_enter_end  = ((w_state_nxt == S_OVER) | (w_state_nxt == S_WIN)) & ~w_end;

  // Next-state: a fatal hit outranks everything, a boss kill outranks pause.
  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    case (r_state)
      S_IDLE: if (w_enter_edge) w_state_nxt = S_PLAY;
      S_PLAY: begin
        if (w_fatal) begin
          w_state_nxt = S_OVER;
        end else if (w_pause_edge) begin
          w_state_nxt = S_PAUSE;
          w_ret_nxt   = S_PLAY;
        end else if (r_score >= BOSS_SCORE) begin
          w_state_nxt = S_BOSS;
        end
      end
      S_BOSS: begin
        if (w_fatal) begin
          w_state_nxt = S_OVER;
        end else if (bus.boss_kill) begin
          w_state_nxt = S_WIN;
        end else if (w_pause_edge) begin
          w_state_nxt = S_PAUSE;
          w_ret_nxt   = S_BOSS;
        end
      end
      S_PAUSE: if (w_pause_edge) w_state_nxt = r_ret;
      S_OVER, S_WIN: if (w_start) w_state_nxt = S_PLAY;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_score_kill = bus.enemy_kill ? bcd_add(r_score, 16'h0001) : r_score;
    w_score_nxt  = r_score;
    w_lives_nxt  = r_lives;
    w_inv_nxt    = r_inv_cnt;
    w_hold_nxt   = r_hold;

    if (w_start) begin
      w_score_nxt = '0;
    end else if (w_active) begin
      w_score_nxt = (r_state == S_BOSS && bus.boss_kill) ?
                    bcd_add(w_score_kill, BOSS_POINTS) : w_score_kill;
    end

    if (w_start)      w_lives_nxt = LIVES_INIT;
    else if (w_fatal) w_lives_nxt = 2'd0;
    else if (w_hit)   w_lives_nxt = r_lives - 2'd1;

    if (w_start)
      w_inv_nxt = '0;
    else if (w_hit && !w_fatal)
      w_inv_nxt = INV_LOAD;
    else if (bus.tick && r_state != S_PAUSE && r_inv_cnt != '0)
      w_inv_nxt = r_inv_cnt - 1'b1;

    if (w_enter_end)
      w_hold_nxt = HOLD_LOAD;
    else if (w_end && bus.tick && r_hold != '0)
      w_hold_nxt = r_hold - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ret        <= S_PLAY;
      r_enter_d    <= 1'b0;
      r_pause_d    <= 1'b0;
      r_lives      <= 2'd0;
      r_score      <= '0;
      r_inv_cnt    <= '0;
      r_hold       <= '0;
      r_round_rst  <= 1'b0;
      r_boss_spawn <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ret        <= w_ret_nxt;
      r_enter_d    <= bus.enter;
      r_pause_d    <= bus.pause_key;
      r_lives      <= w_lives_nxt;
      r_score      <= w_score_nxt;
      r_inv_cnt    <= w_inv_nxt;
      r_hold       <= w_hold_nxt;
      r_round_rst  <= w_start;
      r_boss_spawn <= (r_state == S_PLAY) & (w_state_nxt == S_BOSS);
    end
  end

`ifdef GAME_HISCORE_EN
  logic [15:0] r_hiscore;

  // Valid BCD orders the same as binary, so a plain magnitude compare suffices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_hiscore <= '0;
    else if (w_enter_end && (w_score_nxt > r_hiscore))
      r_hiscore <= w_score_nxt;
  end

  assign bus.hiscore_bcd = r_hiscore;
`else
  assign bus.hiscore_bcd = 16'h0000;
`endif

  always_comb begin
    bus.state      = r_state;
    bus.play_en    = (r_state == S_PLAY) | (r_state == S_BOSS) | (r_state == S_PAUSE);
    bus.freeze     = (r_state == S_PAUSE);
    bus.round_rst  = r_round_rst;
    bus.boss_spawn = r_boss_spawn;
    bus.lives      = r_lives;
    bus.invuln     = (r_inv_cnt != '0);
    bus.score_bcd  = r_score;
  end

endmodule
